// File: rtl/sw_input_conditioner.sv
// Multi-channel switch/button conditioner: sync, polarity, debounce,
// edge pulses, press-toggle latch and long-press detect per channel.
module sw_input_conditioner #(
    parameter int unsigned          CH          = 8,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [CH-1:0]        INV_MASK    = '0,
    parameter int unsigned          DB_CYCLES   = 50000,
    parameter longint unsigned      LONG_CYCLES = 64'd50000000
) (
    input  logic          iSysClk,
    input  logic          iSysRst,
    input  logic [CH-1:0] iSw,
    input  logic [CH-1:0] iClrToggle,
    output logic [CH-1:0] oLevel,
    output logic [CH-1:0] oRise,
    output logic [CH-1:0] oFall,
    output logic [CH-1:0] oToggle,
    output logic [CH-1:0] oLong
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

    logic [SYNC_STAGES-1:0][CH-1:0] r_sync;
    logic [DB_W-1:0]                r_dbcnt [CH];
    logic [LONG_W-1:0]              r_hold  [CH];

    logic [CH-1:0] r_level;
    logic [CH-1:0] r_rise;
    logic [CH-1:0] r_fall;
    logic [CH-1:0] r_toggle;
    logic [CH-1:0] r_long;

    logic [CH-1:0] w_sync;
    logic [CH-1:0] w_db_hit;
    logic [CH-1:0] w_rise;
    logic [CH-1:0] w_fall;
    logic [CH-1:0] w_long_hit;

    always_comb begin
        w_sync     = r_sync[SYNC_STAGES-1];
        w_db_hit   = '0;
        w_long_hit = '0;
        for (int ch = 0; ch < int'(CH); ch++) begin
            w_db_hit[ch]   = (w_sync[ch] != r_level[ch]) &&
                             (r_dbcnt[ch] == DB_LAST);
            w_long_hit[ch] = r_level[ch] && (r_hold[ch] == LONG_LAST);
        end
        w_rise = w_db_hit & w_sync;
        w_fall = w_db_hit & ~w_sync;
    end

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            r_sync   <= '0;
            r_level  <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_toggle <= '0;
            r_long   <= '0;
            for (int ch = 0; ch < int'(CH); ch++) begin
                r_dbcnt[ch] <= '0;
                r_hold[ch]  <= '0;
            end
        end else begin
            // Polarity is corrected before the first synchroniser flop.
            r_sync   <= {r_sync[SYNC_STAGES-2:0], iSw ^ INV_MASK};
            r_level  <= r_level ^ w_db_hit;
            r_rise   <= w_rise;
            r_fall   <= w_fall;
            r_toggle <= (r_toggle ^ w_rise) & ~iClrToggle;
            r_long   <= w_long_hit;
            for (int ch = 0; ch < int'(CH); ch++) begin
                if ((w_sync[ch] == r_level[ch]) || w_db_hit[ch])
                    r_dbcnt[ch] <= '0;
                else
                    r_dbcnt[ch] <= r_dbcnt[ch] + DB_W'(1);

                // Parking one past the threshold blocks a repeat pulse.
                if (!r_level[ch])
                    r_hold[ch] <= '0;
                else if (r_hold[ch] != LONG_SAT)
                    r_hold[ch] <= r_hold[ch] + LONG_W'(1);
            end
        end
    end

    assign oLevel  = r_level;
    assign oRise   = r_rise;
    assign oFall   = r_fall;
    assign oToggle = r_toggle;
    assign oLong   = r_long;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Bench for sw_input_conditioner: vector table, directed corner
// sequences and random stimulus against a window-based reference model.
module tb_sw_input_conditioner;

    localparam int         CH    = 4;
    localparam int         SYNC  = 2;
    localparam int         DB    = 4;
    localparam int         LONG  = 20;
    localparam logic [3:0] INV   = 4'b0100;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] clr;
    logic [3:0] o_level, o_rise, o_fall, o_tog, o_long;

    sw_input_conditioner #(
        .CH          (CH),
        .SYNC_STAGES (SYNC),
        .INV_MASK    (INV),
        .DB_CYCLES   (DB),
        .LONG_CYCLES (LONG)
    ) dut (
        .iSysClk    (clk),
        .iSysRst    (rst),
        .iSw        (sw),
        .iClrToggle (clr),
        .oLevel     (o_level),
        .oRise      (o_rise),
        .oFall      (o_fall),
        .oToggle    (o_tog),
        .oLong      (o_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a level flips once the last DB synchronised
    // samples all disagree with it; samples reach the logic SYNC edges late.
    logic [3:0] xq[$];
    logic [3:0] m_level, m_rise, m_fall, m_tog, m_long;
    int         rise_at [CH];
    int         n_edge = 0;

    task automatic model_reset();
        xq = {};
        for (int i = 0; i < SYNC + DB; i++) xq.push_front(4'b0000);
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_tog   = '0;
        m_long  = '0;
        for (int c = 0; c < CH; c++) rise_at[c] = -100000;
    endtask

    task automatic model_edge(input logic [3:0] s, input logic [3:0] c);
        logic old;
        logic flip;
        n_edge++;
        xq.push_front(s ^ INV);
        if (xq.size() > SYNC + DB) void'(xq.pop_back());
        for (int ch = 0; ch < CH; ch++) begin
            old  = m_level[ch];
            flip = 1'b1;
            for (int j = SYNC; j < SYNC + DB; j++)
                if (xq[j][ch] == old) flip = 1'b0;
            m_long[ch] = old && ((n_edge - rise_at[ch]) == LONG);
            m_rise[ch] = flip && !old;
            m_fall[ch] = flip && old;
            if (flip) m_level[ch] = ~old;
            if (m_rise[ch]) rise_at[ch] = n_edge;
            m_tog[ch] = c[ch] ? 1'b0 : (m_tog[ch] ^ m_rise[ch]);
        end
    endtask

    logic [3:0] cur_sw;
    logic [3:0] cur_clr;

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        sw  = cur_sw;
        clr = cur_clr;
        @(posedge clk);
        model_edge(cur_sw, cur_clr);
        @(negedge clk);
        chk("model_level", int'(o_level), int'(m_level));
        chk("model_rise",  int'(o_rise),  int'(m_rise));
        chk("model_fall",  int'(o_fall),  int'(m_fall));
        chk("model_tog",   int'(o_tog),   int'(m_tog));
        chk("model_long",  int'(o_long),  int'(m_long));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // sel: 0 rise, 1 fall, 2 long. n = -1 when the bound expires.
    task automatic steps_until(input int ch, input int sel,
                               input int maxn, output int n);
        logic found;
        found = 1'b0;
        n     = 0;
        while (!found && n < maxn) begin
            step();
            n++;
            case (sel)
                0: found = o_rise[ch];
                1: found = o_fall[ch];
                default: found = o_long[ch];
            endcase
        end
        if (!found) n = -1;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        chk({name, "_level"}, int'(o_level), 0);
        chk({name, "_rise"},  int'(o_rise),  0);
        chk({name, "_fall"},  int'(o_fall),  0);
        chk({name, "_tog"},   int'(o_tog),   0);
        chk({name, "_long"},  int'(o_long),  0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] sw;
        logic [3:0] level;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] tog;
        logic [3:0] lng;
    } vec_t;

    vec_t tbl [8];
    int   n;
    int   rises;
    int   longs;
    int   r_at;
    int   l_at;
    logic bp [8];

    initial begin
        rst     = 1'b1;
        cur_sw  = 4'b0100;
        cur_clr = 4'b0000;
        sw      = cur_sw;
        clr     = cur_clr;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset("reset");

        // ch0 pressed and inverted ch2 driven low: both settle on edge 6.
        for (int i = 0; i < 8; i++) begin
            tbl[i].sw    = 4'b0001;
            tbl[i].level = (i >= 5) ? 4'b0101 : 4'b0000;
            tbl[i].rise  = (i == 5) ? 4'b0101 : 4'b0000;
            tbl[i].fall  = 4'b0000;
            tbl[i].tog   = (i >= 5) ? 4'b0101 : 4'b0000;
            tbl[i].lng   = 4'b0000;
        end
        for (int i = 0; i < 8; i++) begin
            cur_sw = tbl[i].sw;
            step();
            chk($sformatf("tbl%0d_level", i), int'(o_level), int'(tbl[i].level));
            chk($sformatf("tbl%0d_rise", i),  int'(o_rise),  int'(tbl[i].rise));
            chk($sformatf("tbl%0d_fall", i),  int'(o_fall),  int'(tbl[i].fall));
            chk($sformatf("tbl%0d_tog", i),   int'(o_tog),   int'(tbl[i].tog));
            chk($sformatf("tbl%0d_long", i),  int'(o_long),  int'(tbl[i].lng));
        end

        cur_sw[2] = 1'b1;
        steps_until(2, 1, 20, n);
        chk("inv_fall_latency", n, 6);

        bp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rises = 0;
        r_at  = -1;
        for (int i = 1; i <= 14; i++) begin
            cur_sw[1] = (i <= 8) ? bp[i-1] : 1'b1;
            step();
            if (o_rise[1]) begin
                rises++;
                r_at = i;
            end
        end
        chk("bounce_rises", rises, 1);
        chk("bounce_rise_step", r_at, 10);

        cur_sw[3] = 1'b1;
        longs = 0;
        r_at  = -1;
        l_at  = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (o_rise[3]) r_at = i;
            if (o_long[3]) begin
                longs++;
                l_at = i;
            end
        end
        chk("long_rise_step", r_at, 6);
        chk("long_count", longs, 1);
        chk("long_delay", l_at - r_at, LONG);

        longs = 0;
        rises = 0;
        for (int i = 0; i < 34; i++) begin
            cur_sw[3] = (i >= 12 && i < 22) ? 1'b1 : 1'b0;
            step();
            if (o_long[3]) longs++;
            if (o_rise[3]) rises++;
        end
        chk("short_press_rises", rises, 1);
        chk("short_press_long", longs, 0);

        chk("toggle_first", int'(o_tog[0]), 1);
        cur_sw[0] = 1'b0;
        run(10);
        cur_sw[0] = 1'b1;
        steps_until(0, 0, 20, n);
        chk("toggle2_latency", n, 6);
        chk("toggle_second", int'(o_tog[0]), 0);
        cur_sw[0] = 1'b0;
        run(10);
        cur_sw[0] = 1'b1;
        run(5);
        cur_clr[0] = 1'b1;
        step();
        cur_clr[0] = 1'b0;
        chk("clr_rise", int'(o_rise[0]), 1);
        chk("clr_wins", int'(o_tog[0]), 0);
        cur_sw[0] = 1'b0;
        run(10);
        cur_sw[0] = 1'b1;
        steps_until(0, 0, 20, n);
        chk("after_clr_latency", n, 6);
        chk("after_clr_toggle", int'(o_tog[0]), 1);

        cur_sw[0] = 1'b0;
        run(10);
        cur_sw[0] = 1'b1;
        run(3);
        do_reset("midrst");
        steps_until(0, 0, 20, n);
        chk("midrst_rise_latency", n, 6);

        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < CH; b++) begin
                if ($urandom_range(5) == 0) cur_sw[b] = ~cur_sw[b];
                cur_clr[b] = ($urandom_range(9) == 0);
            end
            step();
            if (i == 200) do_reset("randrst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
